data_mem_sized: RTL and testbench

- Next-generation CPU data memory: single-port, word-organised, little-endian.
- Supports byte, half-word and word loads/stores, with sign/zero extension on loads.
- Has a valid/ready request channel, a registered one-cycle read response and an error flag for misaligned or out-of-range accesses.
- After reset, a clear engine zeroes the array one word per cycle, replacing the single-cycle bulk clear. Sits between the MEM pipeline stage and the array storage.

---
 rtl/data_mem_pkg.sv | 30 +++
 rtl/data_mem_lane_align.sv | 52 +++++
 rtl/data_mem_sized.sv | 149 ++++++++++++++
 tb/tb_data_mem_sized.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared encodings and helpers for the sized data memory.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package data_mem_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Controller state: zeroing the array, or serving requests
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Ceiling log2, used to size the word index from DEPTH
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/data_mem_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data, load extraction with extension.
// Latency: purely combinational.
// Backpressure: none; reused by the instruction-fetch memory.
module data_mem_lane_align
    import data_mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] byte_sh;
    logic [31:0] half_sh;

    // Lane selection for stores and right-justification plus extension for loads
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        rdata_o = 32'h0;
        byte_sh = rword_i >> {lane_i, 3'b000};
        half_sh = rword_i >> {lane_i[1], 4'b0000};
        case (size_i)
            SZ_BYTE: begin
                // Replicating the byte lets the enable mask alone pick the lane
                be_o    = 4'b0001 << lane_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{signed_i & byte_sh[7]}}, byte_sh[7:0]};
            end
            SZ_HALF: begin
                be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{signed_i & half_sh[15]}}, half_sh[15:0]};
            end
            SZ_WORD: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rword_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = 32'h0;
                rdata_o = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_sized.sv
// Single-port little-endian data memory with byte/half/word access and a post-reset clear engine.
// Latency: response (rsp_valid/rdata/err) one cycle after the accepting edge; clear takes DEPTH cycles.
// Backpressure: req_ready low only while clearing; response channel has no backpressure.
module data_mem_sized
    import data_mem_pkg::*;
#(
    parameter int DEPTH          = 256,
    parameter int ADDR_W         = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              init_busy
);

    localparam int IDX_W = clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    // First byte address past the array; one extra bit so DEPTH*4 never wraps
    localparam logic [ADDR_W:0]  ADDR_LIMIT = (ADDR_W + 1)'(DEPTH * 4);

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             req_ready_q;
    logic             init_busy_q;
    logic             rsp_valid_q;
    logic [31:0]      rsp_rdata_q;
    logic             rsp_err_q;
    logic [31:0]      rsp_rdata_d;
    logic             rsp_err_d;

    logic [31:0]      mem_q [DEPTH];

    logic             accept;
    logic             err_oor;
    logic             err_size;
    logic             err_align;
    logic             req_err;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      rword;
    logic [3:0]       be;
    logic [31:0]      wdata_sh;
    logic [31:0]      rdata_ext;
    logic             store_we;
    logic             clear_we;

    assign accept    = req_valid && req_ready_q;
    assign word_idx  = req_addr[IDX_W+1:2];
    assign err_oor   = ({1'b0, req_addr} >= ADDR_LIMIT);
    assign err_size  = (req_size == SZ_RSVD);
    assign err_align = ((req_size == SZ_HALF) && req_addr[0]) ||
                       ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign req_err   = err_oor || err_size || err_align;
    assign store_we  = accept && req_wr && !req_err;
    // req_ready is forced low by reset, so no store can land while reset is held
    assign clear_we  = (state_q == CLEAR);
    // Asynchronous array read: a store at edge N is visible to a load accepted at N+1
    assign rword     = mem_q[word_idx];

    data_mem_lane_align u_lane_align (
        .size_i   (req_size),
        .lane_i   (req_addr[1:0]),
        .signed_i (req_signed),
        .wdata_i  (req_wdata),
        .rword_i  (rword),
        .be_o     (be),
        .wdata_o  (wdata_sh),
        .rdata_o  (rdata_ext)
    );

    // Clear/run controller with registered handshake and busy outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= CLEAR_ON_RESET ? CLEAR : RUN;
            idx_q       <= '0;
            req_ready_q <= 1'b0;
            init_busy_q <= CLEAR_ON_RESET;
        end else begin
            case (state_q)
                CLEAR: begin
                    idx_q <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_q     <= RUN;
                        idx_q       <= '0;
                        req_ready_q <= 1'b1;
                        init_busy_q <= 1'b0;
                    end
                end
                RUN: begin
                    req_ready_q <= 1'b1;
                    init_busy_q <= 1'b0;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    // Array storage: clear engine zeroes one word per cycle, stores update only enabled lanes
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem_q[idx_q] <= 32'h0;
        end else if (store_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    // Response payload: zero for stores and rejected accesses
    always_comb begin
        rsp_err_d   = req_err;
        rsp_rdata_d = (req_err || req_wr) ? 32'h0 : rdata_ext;
    end

    // Response registers: valid pulses one cycle, payload holds until the next response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= accept;
            if (accept) begin
                rsp_rdata_q <= rsp_rdata_d;
                rsp_err_q   <= rsp_err_d;
            end
        end
    end

    assign req_ready = req_ready_q;
    assign init_busy = init_busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_sized.sv
// Directed self-checking bench for data_mem_sized with DEPTH=16.
// Latency: drives at negedge, samples responses at the following negedge.
// Backpressure: waits on init_busy with a bounded cycle budget.
module tb_data_mem_sized;
    import data_mem_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_busy;

    int checks = 0;
    int errors = 0;

    data_mem_sized #(
        .DEPTH          (16),
        .ADDR_W         (32),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .init_busy  (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                         input logic sgn, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_wr     = wr;
        req_addr   = addr;
        req_size   = sz;
        req_signed = sgn;
        req_wdata  = wd;
    endtask

    // One request, then check the response one cycle later
    task automatic xact(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [1:0] sz, input logic sgn, input logic [31:0] wd,
                        input logic [31:0] exp_data, input logic exp_err);
        drive(wr, addr, sz, sgn, wd);
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, "_vld"}, {31'h0, rsp_valid}, 32'h1);
        chk({tag, "_dat"}, rsp_rdata, exp_data);
        chk({tag, "_err"}, {31'h0, rsp_err}, {31'h0, exp_err});
    endtask

    // Count cycles of init_busy from the current negedge; bounded
    task automatic wait_clear(input string tag);
        int n;
        int ready_seen;
        n = 0;
        ready_seen = 0;
        while (init_busy && n < 1000) begin
            if (req_ready) ready_seen++;
            n++;
            @(negedge clk);
        end
        chk({tag, "_len"}, n, 16);
        chk({tag, "_rdy_low"}, ready_seen, 0);
        chk({tag, "_rdy_after"}, {31'h0, req_ready}, 32'h1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdy"},  {31'h0, req_ready}, 32'h0);
        chk({tag, "_vld"},  {31'h0, rsp_valid}, 32'h0);
        chk({tag, "_dat"},  rsp_rdata, 32'h0);
        chk({tag, "_err"},  {31'h0, rsp_err}, 32'h0);
        chk({tag, "_busy"}, {31'h0, init_busy}, 32'h1);
    endtask

    initial begin
        logic [31:0] exp_w;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_wr     = 1'b0;
        req_addr   = 32'h0;
        req_size   = SZ_WORD;
        req_signed = 1'b0;
        req_wdata  = 32'h0;

        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");

        reset = 1'b1;
        wait_clear("clear");

        // Cleared array reads as zero
        xact("rd0_14", 1'b0, 32'h14, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0);
        xact("rd0_3c", 1'b0, 32'h3C, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0);

        // Word store and sized loads
        xact("st_w8",  1'b1, 32'h8, SZ_WORD, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0);
        xact("ld_w8",  1'b0, 32'h8, SZ_WORD, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
        xact("ld_sbB", 1'b0, 32'hB, SZ_BYTE, 1'b1, 32'h0, 32'hFFFFFFDE, 1'b0);
        xact("ld_uhA", 1'b0, 32'hA, SZ_HALF, 1'b0, 32'h0, 32'h0000DEAD, 1'b0);
        xact("ld_sb8", 1'b0, 32'h8, SZ_BYTE, 1'b1, 32'h0, 32'hFFFFFFEF, 1'b0);
        xact("ld_sh8", 1'b0, 32'h8, SZ_HALF, 1'b1, 32'h0, 32'hFFFFBEEF, 1'b0);
        xact("ld_ub9", 1'b0, 32'h9, SZ_BYTE, 1'b0, 32'h0, 32'h000000BE, 1'b0);

        // Back-to-back byte store then word load of the same word
        drive(1'b1, 32'h9, SZ_BYTE, 1'b0, 32'h0000005A);
        @(negedge clk);
        chk("b2b_st_vld", {31'h0, rsp_valid}, 32'h1);
        drive(1'b0, 32'h8, SZ_WORD, 1'b0, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_ld_vld", {31'h0, rsp_valid}, 32'h1);
        chk("b2b_ld_dat", rsp_rdata, 32'hDEAD5AEF);

        // Response payload holds, valid drops when idle
        @(negedge clk);
        chk("idle_vld",  {31'h0, rsp_valid}, 32'h0);
        chk("idle_hold", rsp_rdata, 32'hDEAD5AEF);

        // Rejected accesses, each followed by a read showing the array untouched
        xact("err_h3",   1'b0, 32'h3,  SZ_HALF, 1'b0, 32'h0, 32'h0, 1'b1);
        xact("err_hB",   1'b0, 32'hB,  SZ_HALF, 1'b1, 32'h0, 32'h0, 1'b1);
        xact("err_w6",   1'b1, 32'h6,  SZ_WORD, 1'b0, 32'h12345678, 32'h0, 1'b1);
        xact("chk_w4",   1'b0, 32'h4,  SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0);
        xact("chk_w8a",  1'b0, 32'h8,  SZ_WORD, 1'b0, 32'h0, 32'hDEAD5AEF, 1'b0);
        xact("err_rsv",  1'b1, 32'h8,  SZ_RSVD, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1);
        xact("chk_w8b",  1'b0, 32'h8,  SZ_WORD, 1'b0, 32'h0, 32'hDEAD5AEF, 1'b0);
        xact("err_oor",  1'b1, 32'h40, SZ_WORD, 1'b0, 32'hCAFEF00D, 32'h0, 1'b1);
        xact("chk_w0",   1'b0, 32'h0,  SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0);
        xact("err_oorl", 1'b0, 32'h48, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b1);

        // Streaming: fill words 0..7, then eight back-to-back loads
        for (int i = 0; i < 8; i++) begin
            exp_w = 32'h11111111 * 32'(i + 1);
            xact("fill", 1'b1, 32'(4 * i), SZ_WORD, 1'b0, exp_w, 32'h0, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 32'(4 * i), SZ_WORD, 1'b0, 32'h0);
            @(negedge clk);
            exp_w = 32'h11111111 * 32'(i + 1);
            chk("stream_vld", {31'h0, rsp_valid}, 32'h1);
            chk("stream_dat", rsp_rdata, exp_w);
        end
        req_valid = 1'b0;
        @(negedge clk);
        chk("stream_end_vld", {31'h0, rsp_valid}, 32'h0);

        // Asynchronous reset with a held nonzero response
        reset = 1'b0;
        #1;
        chk_reset_outputs("arst");

        // Reset pulsed mid-clear at index 5
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_busy", {31'h0, init_busy}, 32'h1);
        reset = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        @(negedge clk);
        reset = 1'b1;
        wait_clear("reclear");
        xact("rc_w5", 1'b0, 32'h14, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0);
        xact("rc_w7", 1'b0, 32'h1C, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0);
        xact("rc_w0", 1'b0, 32'h0,  SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
